fg_prog_sequencer: RTL

//  Closed-loop floating-gate programming sequencer for one island's indirect FG matrix
//  (4x2 indirect cells plus drain-select/prog-switch mux). Accepts one target per request.
//  Per request: selects the cell via decoder/switch lines, then alternates measure and
//  hot-electron-injection pulses until the measured code reaches the target.

---
 rtl/fg_prog_pkg.sv | 24 ++
 rtl/fg_cycle_timer.sv | 37 +++
 rtl/fg_prog_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fg_prog_pkg.sv
// Shared types for the floating-gate programming sequencer: FSM states,
// response status codes and the response pulse-count width.
package fg_prog_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        MEASURE = 3'd2,
        CHECK   = 3'd3,
        PULSE   = 3'd4,
        RECOVER = 3'd5,
        RESP    = 3'd6
    } fg_state_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_ALREADY = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_ABORTED = 2'b11
    } fg_status_e;

    localparam int RSP_PULSE_W = 8;

endpackage

// File: rtl/fg_cycle_timer.sv
// Loadable down-counter used to time settle windows and injection pulses.
// Loading N gives done=1 after exactly N further clock edges, so a state that
// leaves on done after a load of N-1 lasts exactly N cycles.
module fg_cycle_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// Closed-loop floating-gate programming sequencer: selects one indirect FG
// cell, then alternates ADC measurements and hot-electron injection pulses
// until the measured code reaches the requested target, the pulse budget is
// spent, or the host aborts.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is high only while idle; rsp_valid stays high and all
// rsp_* fields stay frozen until rsp_ready is seen; meas_req stays high until
// meas_ack, and meas_code is taken in the ack cycle.
module fg_prog_sequencer
    import fg_prog_pkg::*;
#(
    parameter int ROW_BITS   = 3,
    parameter int COL_BITS   = 1,
    parameter int CODE_W     = 10,
    parameter int PULSE_W    = 12,
    parameter int SETTLE_CYC = 16,
    parameter int MAX_PULSES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ROW_BITS-1:0]    req_row,
    input  logic [COL_BITS-1:0]    req_col,
    input  logic [CODE_W-1:0]      req_target,
    input  logic [PULSE_W-1:0]     pulse_len,
    input  logic                   abort,
    output logic [ROW_BITS-1:0]    row_sel,
    output logic [COL_BITS-1:0]    col_sel,
    output logic                   prog_mode,
    output logic                   inj_pulse,
    output logic                   meas_req,
    input  logic                   meas_ack,
    input  logic [CODE_W-1:0]      meas_code,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_status,
    output logic [RSP_PULSE_W-1:0] rsp_pulses,
    output logic [CODE_W-1:0]      rsp_code,
    output logic [2:0]             dbg_state
);

    localparam logic [PULSE_W-1:0]     SETTLE_LOAD = PULSE_W'(SETTLE_CYC - 1);
    localparam logic [RSP_PULSE_W-1:0] MAX_CNT     = RSP_PULSE_W'(MAX_PULSES);

    fg_state_e               state_q, state_d;
    logic [ROW_BITS-1:0]     row_q, row_d;
    logic [COL_BITS-1:0]     col_q, col_d;
    logic [CODE_W-1:0]       target_q, target_d;
    logic [PULSE_W-1:0]      plen_q, plen_d;
    logic [RSP_PULSE_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0]       code_q, code_d;
    logic [1:0]              rsp_status_q, rsp_status_d;
    logic [RSP_PULSE_W-1:0]  rsp_pulses_q, rsp_pulses_d;
    logic [CODE_W-1:0]       rsp_code_q, rsp_code_d;
    logic                    req_ready_q, req_ready_d;
    logic                    prog_mode_q, prog_mode_d;
    logic                    inj_pulse_q, inj_pulse_d;
    logic                    meas_req_q, meas_req_d;
    logic                    rsp_valid_q, rsp_valid_d;

    logic                    timer_load;
    logic [PULSE_W-1:0]      timer_val;
    logic                    timer_done;
    logic                    abort_now;
    logic                    go_resp;
    logic [1:0]              resp_status;

    fg_cycle_timer #(.W(PULSE_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // Abort only matters while a request is in flight.
    assign abort_now = abort && (state_q != IDLE) && (state_q != RESP);

    // Next-state, request capture, pulse bookkeeping and registered outputs.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        target_d     = target_q;
        plen_d       = plen_q;
        cnt_d        = cnt_q;
        code_d       = code_q;
        rsp_status_d = rsp_status_q;
        rsp_pulses_d = rsp_pulses_q;
        rsp_code_d   = rsp_code_q;
        timer_load   = 1'b0;
        timer_val    = SETTLE_LOAD;
        go_resp      = 1'b0;
        resp_status  = ST_OK;

        if (abort_now) begin
            go_resp     = 1'b1;
            resp_status = ST_ABORTED;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        state_d    = SETUP;
                        row_d      = req_row;
                        col_d      = req_col;
                        target_d   = req_target;
                        plen_d     = (pulse_len == '0) ? PULSE_W'(1) : pulse_len;
                        cnt_d      = '0;
                        code_d     = '0;
                        timer_load = 1'b1;
                    end
                end
                SETUP: begin
                    if (timer_done) state_d = MEASURE;
                end
                MEASURE: begin
                    if (meas_ack) begin
                        code_d  = meas_code;
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    // Target check comes before the budget check, so reaching
                    // the target on the last allowed pulse still reports OK.
                    if (code_q >= target_q) begin
                        go_resp     = 1'b1;
                        resp_status = (cnt_q == '0) ? ST_ALREADY : ST_OK;
                    end else if (cnt_q >= MAX_CNT) begin
                        go_resp     = 1'b1;
                        resp_status = ST_TIMEOUT;
                    end else begin
                        state_d    = PULSE;
                        timer_load = 1'b1;
                        timer_val  = plen_q - PULSE_W'(1);
                    end
                end
                PULSE: begin
                    if (timer_done) begin
                        cnt_d      = (cnt_q >= MAX_CNT) ? cnt_q : cnt_q + RSP_PULSE_W'(1);
                        state_d    = RECOVER;
                        timer_load = 1'b1;
                    end
                end
                RECOVER: begin
                    if (timer_done) state_d = MEASURE;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_d      = IDLE;
                        row_d        = '0;
                        col_d        = '0;
                        rsp_status_d = '0;
                        rsp_pulses_d = '0;
                        rsp_code_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Freeze the response fields on the way into RESP; an aborted pulse
        // is not counted because cnt_q only advances when a pulse completes.
        if (go_resp) begin
            state_d      = RESP;
            rsp_status_d = resp_status;
            rsp_pulses_d = cnt_q;
            rsp_code_d   = code_q;
        end

        req_ready_d = (state_d == IDLE);
        prog_mode_d = (state_d == SETUP) || (state_d == MEASURE) || (state_d == CHECK) ||
                      (state_d == PULSE) || (state_d == RECOVER);
        inj_pulse_d = (state_d == PULSE);
        meas_req_d  = (state_d == MEASURE);
        rsp_valid_d = (state_d == RESP);
    end

    // State, request context and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            target_q     <= '0;
            plen_q       <= '0;
            cnt_q        <= '0;
            code_q       <= '0;
            rsp_status_q <= '0;
            rsp_pulses_q <= '0;
            rsp_code_q   <= '0;
            req_ready_q  <= 1'b1;
            prog_mode_q  <= 1'b0;
            inj_pulse_q  <= 1'b0;
            meas_req_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            target_q     <= target_d;
            plen_q       <= plen_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            rsp_status_q <= rsp_status_d;
            rsp_pulses_q <= rsp_pulses_d;
            rsp_code_q   <= rsp_code_d;
            req_ready_q  <= req_ready_d;
            prog_mode_q  <= prog_mode_d;
            inj_pulse_q  <= inj_pulse_d;
            meas_req_q   <= meas_req_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign row_sel    = row_q;
    assign col_sel    = col_q;
    assign prog_mode  = prog_mode_q;
    assign inj_pulse  = inj_pulse_q;
    assign meas_req   = meas_req_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_status_q;
    assign rsp_pulses = rsp_pulses_q;
    assign rsp_code   = rsp_code_q;
    assign dbg_state  = state_q;

endmodule
